// File: rtl/mc_control_unit_pkg.sv
// Purpose : shared types and constants for the multi-cycle MIPS control unit.
//           Holds the FSM state enum, opcode/funct encodings, the ALU
//           operation codes (also used by the ALU) and a Moore output
//           decode helper.
// Ports   : none (package).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_REXEC,
    S_RWB,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_BEQ,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type funct, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd7;

  // PC source selects
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // ALU B-operand selects
  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // Outputs that depend on state only
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] pc_src;
    logic       pc_en;
  } ctrl_out_t;

  function automatic ctrl_out_t state_outputs(input state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.mem_rd    = 1'b1;
        o.alu_src_b = SRCB_FOUR;
        o.alu_op    = ALU_ADD;
        o.pc_src    = PC_ALU;
      end
      S_DECODE: begin
        o.alu_src_b = SRCB_IMM_SH;
        o.alu_op    = ALU_ADD;
      end
      S_REXEC: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRCB_REG;
      end
      S_RWB: begin
        o.reg_dst   = 1'b1;
        o.reg_write = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRCB_IMM;
        o.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        o.iord   = 1'b1;
        o.mem_rd = 1'b1;
      end
      S_MEMWB: begin
        o.mem_to_reg = 1'b1;
        o.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o.iord   = 1'b1;
        o.mem_wr = 1'b1;
      end
      S_BEQ: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRCB_REG;
        o.alu_op    = ALU_SUB;
        o.pc_src    = PC_ALUOUT;
      end
      S_ADDIWB: begin
        o.reg_write = 1'b1;
      end
      S_JUMP: begin
        o.pc_src = PC_JUMP;
        o.pc_en  = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Purpose : bundle between the control unit and the IR/memory/ALU datapath.
// Ports   : master = control unit (drives selects/enables, reads opcode,
//           funct, zero, mem_ready); slave = datapath side.
interface mc_control_unit_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal_op;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, iord, mem_rd, mem_wr, ir_write,
           reg_dst, mem_to_reg, reg_write, pc_src, pc_en, illegal_op
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, iord, mem_rd, mem_wr, ir_write,
           reg_dst, mem_to_reg, reg_write, pc_src, pc_en, illegal_op
  );
endinterface

// File: rtl/mc_control_unit_alu_decoder.sv
// Purpose : combinational R-type funct -> ALU operation decode.
// Ports   : i_funct  instr[5:0]
//           o_alu_op ALU operation (AND when funct is unsupported)
//           o_legal  1 when funct is a supported R-type operation
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = ALU_AND;
    o_legal  = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_AND:  o_alu_op = ALU_AND;
      FN_OR:   o_alu_op = ALU_OR;
      FN_SLT:  o_alu_op = ALU_SLT;
      default: o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Purpose : multi-cycle MIPS control FSM (fetch/decode/execute/memory/
//           writeback) with a memory-wait timeout.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    mc_control_unit_if.master: opcode/funct/zero/mem_ready in,
//                  mux selects, strobes, enables and illegal_op out
// Param   : MEM_WAIT_MAX  wait cycles on mem_ready before aborting to FETCH
//                         with an illegal_op pulse; 0 disables the timeout.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_control_unit_if.master  bus
);

  localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_t           r_state;
  state_t           w_state_next;
  ctrl_out_t        r_out;
  ctrl_out_t        w_out;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_next;

  logic       w_wait_state;
  logic       w_timeout;
  logic       w_illegal;
  logic       w_fetch_go;
  logic       w_beq_take;
  logic       w_ir_write;
  logic       w_illegal_out;
  logic [2:0] w_dec_op;
  logic       w_dec_legal;

  mc_alu_decoder u_alu_decoder (
    .i_funct  (bus.funct),
    .o_alu_op (w_dec_op),
    .o_legal  (w_dec_legal)
  );

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                        (r_state == S_MEMWR);

  generate
    if (MEM_WAIT_MAX != 0) begin : g_timeout
      assign w_timeout = w_wait_state && (r_wait_cnt == CNT_W'(MEM_WAIT_MAX));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  // Next-state and illegal-op decode
  always_comb begin
    w_state_next = r_state;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        // A timed-out fetch restarts in place; PC was never enabled.
        if (w_timeout)          w_illegal    = 1'b1;
        else if (bus.mem_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     w_state_next = S_REXEC;
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_BEQ:       w_state_next = S_BEQ;
          OP_ADDI:      w_state_next = S_ADDIEX;
          OP_J:         w_state_next = S_JUMP;
          default: begin
            w_illegal    = 1'b1;
            w_state_next = S_FETCH;
          end
        endcase
      end
      S_REXEC: begin
        if (w_dec_legal) begin
          w_state_next = S_RWB;
        end else begin
          w_illegal    = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_RWB:    w_state_next = S_FETCH;
      // Only lw/sw reach MEMADR, so anything other than lw is a store.
      S_MEMADR: w_state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (w_timeout) begin
          w_illegal    = 1'b1;
          w_state_next = S_FETCH;
        end else if (bus.mem_ready) begin
          w_state_next = S_MEMWB;
        end
      end
      S_MEMWB:  w_state_next = S_FETCH;
      S_MEMWR: begin
        if (w_timeout) begin
          w_illegal    = 1'b1;
          w_state_next = S_FETCH;
        end else if (bus.mem_ready) begin
          w_state_next = S_FETCH;
        end
      end
      S_BEQ:    w_state_next = S_FETCH;
      S_ADDIEX: w_state_next = S_ADDIWB;
      S_ADDIWB: w_state_next = S_FETCH;
      S_JUMP:   w_state_next = S_FETCH;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // Wait counter: counts stalled cycles in the memory-wait states; any state
  // change or timeout starts the next wait from zero. Saturates when the
  // timeout is disabled so it can never wrap.
  always_comb begin
    w_wait_cnt_next = r_wait_cnt;
    if ((w_state_next != r_state) || w_timeout) begin
      w_wait_cnt_next = '0;
    end else if (w_wait_state && !bus.mem_ready && (r_wait_cnt != '1)) begin
      w_wait_cnt_next = r_wait_cnt + 1'b1;
    end
  end

  // The Moore outputs of the next state are registered alongside it, so r_out
  // always equals state_outputs(r_state) without a decode after the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_out      <= state_outputs(S_FETCH);
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_out      <= state_outputs(w_state_next);
    end
  end

  assign w_fetch_go = (r_state == S_FETCH) && bus.mem_ready && !w_timeout;
  assign w_beq_take = (r_state == S_BEQ) && bus.zero;

  // Final output stage: add the input-dependent terms and force everything
  // low while reset is held (the state already reads FETCH during reset).
  always_comb begin
    w_out         = r_out;
    w_ir_write    = w_fetch_go;
    w_illegal_out = w_illegal;
    if (r_state == S_REXEC) w_out.alu_op = w_dec_op;
    if (w_timeout) begin
      w_out.mem_rd = 1'b0;
      w_out.mem_wr = 1'b0;
    end
    w_out.pc_en = r_out.pc_en | w_fetch_go | w_beq_take;
    if (!rst_n) begin
      w_out         = '0;
      w_ir_write    = 1'b0;
      w_illegal_out = 1'b0;
    end
  end

  assign bus.alu_op     = w_out.alu_op;
  assign bus.alu_src_a  = w_out.alu_src_a;
  assign bus.alu_src_b  = w_out.alu_src_b;
  assign bus.iord       = w_out.iord;
  assign bus.mem_rd     = w_out.mem_rd;
  assign bus.mem_wr     = w_out.mem_wr;
  assign bus.ir_write   = w_ir_write;
  assign bus.reg_dst    = w_out.reg_dst;
  assign bus.mem_to_reg = w_out.mem_to_reg;
  assign bus.reg_write  = w_out.reg_write;
  assign bus.pc_src     = w_out.pc_src;
  assign bus.pc_en      = w_out.pc_en;
  assign bus.illegal_op = w_illegal_out;

endmodule
